// File: rtl/spi_pkg.sv
// Shared definitions for the oversampling SPI responder: FSM encoding,
// default frame length and synchronizer depth.
package spi_pkg;

  localparam int unsigned SPI_M_DEFAULT = 15;
  localparam int unsigned SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FULL
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge
  import spi_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o =  q_o & ~edge_q;
  assign fall_o = ~q_o &  edge_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder running entirely on GCLK: oversamples SCLK/SS/MOSI,
// receives an M-bit word, returns a parallel-loaded word and flags bad frames.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int unsigned M = SPI_M_DEFAULT
) (
  input  logic         GCLK,
  input  logic         RST,
  input  logic         SCLK,
  input  logic         SS,
  input  logic         MOSI,
  output logic         MISO,
  input  logic         LEFT,
  input  logic [M-1:0] DIN,
  output logic [M-1:0] DOUT,
  output logic         DONE,
  output logic         ERR,
  output logic         BUSY
);

  localparam int unsigned CW = $clog2(M + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(M);

  logic       sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic       sclk_lvl_unused, ss_lvl_unused;
  logic [1:0] mosi_edges_unused;

  spi_sync_edge u_sync_sclk (
    .clk_i(GCLK), .rst_ni(RST), .d_i(SCLK),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge u_sync_ss (
    .clk_i(GCLK), .rst_ni(RST), .d_i(SS),
    .q_o(ss_lvl_unused), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync_edge u_sync_mosi (
    .clk_i(GCLK), .rst_ni(RST), .d_i(MOSI),
    .q_o(mosi_s), .rise_o(mosi_edges_unused[0]), .fall_o(mosi_edges_unused[1])
  );

  spi_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  rx_q, rx_d, tx_q, tx_d, dout_q, dout_d;
  logic          left_q, left_d, ovr_q, ovr_d, miso_q, miso_d;
  logic          done_q, done_d, err_q, err_d, busy_q, busy_d;

  always_ff @(posedge GCLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      dout_q  <= '0;
      left_q  <= 1'b0;
      ovr_q   <= 1'b0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      dout_q  <= dout_d;
      left_q  <= left_d;
      ovr_q   <= ovr_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // SS edges are checked before SCLK edges so a coincident SCLK edge is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    dout_d  = dout_q;
    left_d  = left_q;
    ovr_d   = ovr_q;
    miso_d  = miso_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          tx_d    = DIN;
          left_d  = LEFT;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          miso_d  = LEFT ? DIN[M-1] : DIN[0];
          busy_d  = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE, ST_FULL: begin
        if (ss_rise) begin
          if (cnt_q == CNT_MAX && !ovr_q) begin
            dout_d = rx_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (state_q == ST_ACTIVE) begin
          if (sclk_rise) begin
            rx_d  = left_q ? {rx_q[M-2:0], mosi_s} : {mosi_s, rx_q[M-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CNT_MAX) state_d = ST_FULL;
          end else if (sclk_fall) begin
            tx_d   = left_q ? {tx_q[M-2:0], 1'b0} : {1'b0, tx_q[M-1:1]};
            miso_d = left_q ? tx_q[M-2] : tx_q[1];
          end
        end else if (sclk_rise) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign MISO = miso_q;
  assign DOUT = dout_q;
  assign DONE = done_q;
  assign ERR  = err_q;
  assign BUSY = busy_q;

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Synchronous SPI responder that sits opposite the team's `SPI_MASTER` on the same four-wire link (SCLK, MOSI, MISO, SS). It runs entirely in the system clock domain and oversamples the master's pins; no logic is clocked by SCLK. It receives an M-bit word on MOSI while returning a parallel-loaded M-bit word on MISO, and flags short or over-long frames.

## Interface
- `M`, 15: frame length in bits; must be at least 2.
- `GCLK` input 1: system clock; all state updates on its rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `SCLK` input 1: SPI clock from master; idles low (mode 0).
- `SS` input 1: frame select from master (`LOAD`); active-low.
- `MOSI` input 1: serial data from master.
- `MISO` output 1: serial data to master; reset 0.
- `LEFT` input 1: 1 = MSB first, 0 = LSB first; sampled at frame start.
- `DIN` input M: word to transmit; captured at frame start.
- `DOUT` output M: last correctly received word; reset 0.
- `DONE` output 1: one-cycle pulse for a good frame; reset 0.
- `ERR` output 1: one-cycle pulse for a bad frame; reset 0.
- `BUSY` output 1: high from frame start until the frame closes; reset 0.

## Operation
- `SCLK`, `SS` and `MOSI` each pass through a 2-flop synchronizer. Edge detection on `SCLK` and `SS` compares synchronizer stage 2 with a third register.
- FSM states:
  - IDLE → ACTIVE on the `SS` falling edge.
  - ACTIVE → FULL when the bit counter reaches M.
  - ACTIVE or FULL → IDLE on the `SS` rising edge.
- Frame start (`SS` fall):
  - Load the tx shift register from `DIN`.
  - Latch `LEFT`.
  - Clear the bit counter and the overrun flag.
  - Drive `MISO` with `DIN[M-1]` if `LEFT`=1, otherwise `DIN[0]`.
  - Set `BUSY`.
- ACTIVE, on each `SCLK` rising edge:
  - Shift synchronized `MOSI` into the rx register, entering at the LSB end if `LEFT`=1, otherwise at the MSB end.
  - Increment the counter.
- ACTIVE, on each `SCLK` falling edge: shift the tx register and drive the next bit on `MISO`. No shift occurs on the falling edge that follows bit M.
- FULL: further `SCLK` rising edges set the overrun flag. Shift registers and `MISO` hold.
- Frame end (`SS` rise):
  - If counter = M and there is no overrun: copy rx into `DOUT` and pulse `DONE`.
  - Otherwise: pulse `ERR` and leave `DOUT` unchanged.
  - Clear `BUSY`. `MISO` holds its last value.
- Simultaneous edges: an `SS` edge in the same cycle as an `SCLK` edge takes precedence, and that `SCLK` edge is ignored.
- `SS` rising in IDLE (glitch or reset exit) is ignored and produces no pulse.
- Reset asserted mid-frame:
  - All outputs and state clear immediately.
  - After release, the FSM stays in IDLE until the next `SS` fall, even if `SS` is still low.
  - The interrupted frame produces neither `DONE` nor `ERR`.
- Counter width is clog2(M+1). It saturates at M.

## Timing
- Input-to-edge latency is 3 `GCLK` edges: 2 synchronizer stages plus the edge register. The action occurs on the 3rd `GCLK` rising edge after the pin transition.
- `MISO` valid: 3 cycles after `SS` fall for the first bit; 3 cycles after each `SCLK` fall for later bits.
- `DONE`/`ERR`: asserted on the 3rd `GCLK` edge after `SS` rise, high for exactly 1 cycle. `DOUT` updates on that same edge.
- Constraints on the master:
  - `SCLK` high and low phases ≥ 4 `GCLK` periods each.
  - `SS` must fall ≥ 4 `GCLK` periods before the first `SCLK` rise.
  - `SS` must stay high ≥ 4 `GCLK` periods between frames.
  - The divide-by-10 bit clock used with `SPI_MASTER` satisfies all of these.
- Back-to-back frames are supported. `DIN` must be stable from 1 cycle before the detected `SS` fall.

## Structure
- Shared package `spi_pkg`:
  - FSM state encoding (IDLE, ACTIVE, FULL).
  - Default frame length constant (15).
  - `SYNC_STAGES` = 2.
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus rise/fall pulse outputs, with async active-low reset. Instantiated for `SCLK` and `SS`. `MOSI` uses the synchronizer path only (edge outputs unused).
- Top module holds the FSM, counter, rx/tx shift registers and output registers.

## Test plan
- LEFT=1, master sends 15'b010110000110110, `DIN`=15'b110101100110110 → `DOUT`=15'b010110000110110, one `DONE` pulse, master RX = 15'b110101100110110, `ERR` stays 0.
- LEFT=0 with the same words → same `DOUT` and master RX; `MISO` sequence starts with `DIN[0]`=0.
- `SS` raised after 7 `SCLK` cycles → one `ERR` pulse, no `DONE`; `DOUT` retains the previous frame's value.
- 16 `SCLK` rising edges in one frame → overrun, `ERR` pulse, `DOUT` unchanged, `MISO` held after bit 15.
- `RST` low for 2 cycles mid-frame at bit 8 → `DOUT`/`MISO`/`BUSY`=0. No pulse at the subsequent `SS` rise. Next full frame 15'h7FFF → `DOUT`=15'h7FFF and `DONE`.
- Two back-to-back frames with `SS` high for 4 `GCLK` cycles, sending 15'h1234 then 15'h0ABC → two `DONE` pulses; `DOUT` shows 15'h1234 then 15'h0ABC.
